// File: rtl/risc_v_mike_lsu.sv
// risc_v_mike_lsu
// Load/store unit sitting after the ALU. Accepts one memory op at a time from
// EX, runs a request/grant/response transaction on the data-memory port and
// returns exactly one response (data or error) to writeback.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   lsu_req_*           : valid/ready request from EX (we, funct3, addr, wdata, rd)
//   mem_req/we/addr/be/wdata : memory request, held stable until grant or timeout
//   mem_gnt             : memory accepted the request this cycle
//   mem_rvalid/rdata    : load data return (only honoured in WAIT)
//   lsu_rsp_*           : one-cycle response pulse with data, rd, err, byte address
//   lsu_busy            : high whenever the unit is not idle (pipeline hold)
module risc_v_mike_lsu #(
  parameter int TIMEOUT_CYC = 15,
  localparam int DATA_32_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req_valid,
  output logic                 lsu_req_ready,
  input  logic                 lsu_we,
  input  logic [2:0]           lsu_funct3,
  input  logic [DATA_32_W-1:0] lsu_addr,
  input  logic [DATA_32_W-1:0] lsu_wdata,
  input  logic [4:0]           lsu_rd,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_32_W-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [DATA_32_W-1:0] mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_32_W-1:0] mem_rdata,
  output logic                 lsu_rsp_valid,
  output logic [DATA_32_W-1:0] lsu_rsp_rdata,
  output logic [4:0]           lsu_rsp_rd,
  output logic                 lsu_rsp_err,
  output logic [DATA_32_W-1:0] lsu_rsp_addr,
  output logic                 lsu_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Counter value of the last cycle allowed in REQ+WAIT before aborting.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]           state;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [DATA_32_W-1:0] addr_q;
  logic [DATA_32_W-1:0] wdata_q;
  logic [4:0]           rd_q;
  logic [7:0]           cnt_q;
  logic [DATA_32_W-1:0] rsp_rdata_q;
  logic                 rsp_err_q;

  logic                 req_illegal;
  logic                 timeout_hit;
  logic                 in_req;
  logic [3:0]           lane_be;
  logic [DATA_32_W-1:0] lane_wdata;
  logic [DATA_32_W-1:0] shifted;
  logic [DATA_32_W-1:0] load_ext;

  // Decode whether an incoming request can never reach memory: reserved
  // widths, unsigned stores, and halfword/word accesses off their natural
  // alignment. Such requests are answered with an error straight from IDLE.
  always_comb begin
    req_illegal = 1'b0;
    case (lsu_funct3)
      3'b000:  req_illegal = 1'b0;
      3'b001:  req_illegal = lsu_addr[0];
      3'b010:  req_illegal = |lsu_addr[1:0];
      3'b100:  req_illegal = lsu_we;
      3'b101:  req_illegal = lsu_we | lsu_addr[0];
      default: req_illegal = 1'b1;
    endcase
  end

  // Store byte lanes: narrow data is replicated across the word so the
  // memory only has to honour the byte enables.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {addr_q[1], 1'b0};
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Load extraction: bring the addressed byte/halfword down to bit 0, then
  // sign- or zero-extend according to the latched width.
  always_comb begin
    shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext = shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  assign in_req      = (state == S_REQ);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // Memory-side fields are forced to zero outside REQ so nothing stale leaks.
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = in_req ? lane_be : 4'b0000;
  assign mem_wdata = in_req ? lane_wdata : '0;

  assign lsu_req_ready = (state == S_IDLE);
  assign lsu_busy      = (state != S_IDLE);
  assign lsu_rsp_valid = (state == S_RESP);
  assign lsu_rsp_rdata = rsp_rdata_q;
  assign lsu_rsp_err   = rsp_err_q;
  assign lsu_rsp_rd    = rd_q;
  assign lsu_rsp_addr  = addr_q;

  // Transaction FSM. The watchdog counts every REQ/WAIT cycle; a grant or
  // rvalid in the final allowed cycle still completes normally because the
  // completion branch is checked before the timeout branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= 5'd0;
      cnt_q       <= 8'd0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req_valid) begin
            we_q        <= lsu_we;
            funct3_q    <= lsu_funct3;
            addr_q      <= lsu_addr;
            wdata_q     <= lsu_wdata;
            rd_q        <= lsu_rd;
            cnt_q       <= 8'd0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= req_illegal;
            state       <= req_illegal ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_gnt) begin
            state <= we_q ? S_RESP : S_WAIT;
          end else if (timeout_hit) begin
            rsp_err_q <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid) begin
            rsp_rdata_q <= load_ext;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            rsp_err_q <= 1'b1;
            state     <= S_RESP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_v_mike_lsu.sv
// Directed testbench for risc_v_mike_lsu: loads/stores of every width, lane
// placement, illegal requests, the timeout watchdog at its boundary, reset
// in the middle of a load, and requests held while the unit is busy.
module tb_risc_v_mike_lsu;

  logic        clk;
  logic        rst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [4:0]  lsu_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_rdata;
  logic [4:0]  lsu_rsp_rd;
  logic        lsu_rsp_err;
  logic [31:0] lsu_rsp_addr;
  logic        lsu_busy;

  int n_cmp;
  int n_err;

  risc_v_mike_lsu #(.TIMEOUT_CYC(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_we        (lsu_we),
    .lsu_funct3    (lsu_funct3),
    .lsu_addr      (lsu_addr),
    .lsu_wdata     (lsu_wdata),
    .lsu_rd        (lsu_rd),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_rdata (lsu_rsp_rdata),
    .lsu_rsp_rd    (lsu_rsp_rd),
    .lsu_rsp_err   (lsu_rsp_err),
    .lsu_rsp_addr  (lsu_rsp_addr),
    .lsu_busy      (lsu_busy)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Drive the EX-side request inputs.
  task automatic applyStimulus(input logic v, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd);
    lsu_req_valid = v;
    lsu_we        = we;
    lsu_funct3    = f3;
    lsu_addr      = addr;
    lsu_wdata     = wd;
    lsu_rd        = rd;
  endtask

  // Drive the memory-side response inputs.
  task automatic driveMem(input logic gnt, input logic rv, input logic [31:0] rdata);
    mem_gnt    = gnt;
    mem_rvalid = rv;
    mem_rdata  = rdata;
  endtask

  // Advance one clock; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Complete load with zero-wait memory: accept, gnt, rvalid, response.
  task automatic runLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [31:0] exp_data);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0, rd);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    checkOutput({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    step();
    driveMem(1'b0, 1'b1, rdata);
    checkOutput({tag, "_wait_no_req"}, 32'(mem_req), 32'd0);
    checkOutput({tag, "_wait_no_rsp"}, 32'(lsu_rsp_valid), 32'd0);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_rsp_valid"}, 32'(lsu_rsp_valid), 32'd1);
    checkOutput({tag, "_rsp_rdata"}, lsu_rsp_rdata, exp_data);
    checkOutput({tag, "_rsp_err"}, 32'(lsu_rsp_err), 32'd0);
    checkOutput({tag, "_rsp_rd"}, 32'(lsu_rsp_rd), 32'(rd));
    step();
    checkOutput({tag, "_back_idle"}, 32'(lsu_req_ready), 32'd1);
    checkOutput({tag, "_rsp_pulse"}, 32'(lsu_rsp_valid), 32'd0);
  endtask

  // Illegal request: response with err in the cycle after accept, no memory access.
  task automatic runIllegal(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr);
    applyStimulus(1'b1, we, f3, addr, 32'hA5A5A5A5, 5'd3);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(lsu_rsp_valid), 32'd1);
    checkOutput({tag, "_rsp_err"}, 32'(lsu_rsp_err), 32'd1);
    checkOutput({tag, "_rsp_addr"}, lsu_rsp_addr, addr);
    checkOutput({tag, "_rsp_rdata"}, lsu_rsp_rdata, 32'h0);
    checkOutput({tag, "_no_mem_req"}, 32'(mem_req), 32'd0);
    step();
    checkOutput({tag, "_idle"}, 32'(lsu_req_ready), 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b0, 1'b0, 32'h0);

    // Reset state
    step();
    step();
    checkOutput("rst_ready", 32'(lsu_req_ready), 32'd1);
    checkOutput("rst_busy", 32'(lsu_busy), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", lsu_rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(lsu_rsp_err), 32'd0);
    checkOutput("rst_rsp_addr", lsu_rsp_addr, 32'h0);
    checkOutput("rst_rsp_rd", 32'(lsu_rsp_rd), 32'd0);
    rst = 1'b0;
    step();

    // Loads of every width
    runLoad("lw",  3'b010, 32'h0000_0100, 32'hDEADBEEF, 5'd7,  32'hDEADBEEF);
    runLoad("lb",  3'b000, 32'h0000_0103, 32'h80AABBCC, 5'd8,  32'hFFFFFF80);
    runLoad("lbu", 3'b100, 32'h0000_0103, 32'h80AABBCC, 5'd9,  32'h00000080);
    runLoad("lh",  3'b001, 32'h0000_0102, 32'h80AABBCC, 5'd10, 32'hFFFF80AA);
    runLoad("lhu", 3'b101, 32'h0000_0100, 32'h12348765, 5'd11, 32'h00008765);
    runLoad("lb0", 3'b000, 32'h0000_0101, 32'h11223344, 5'd12, 32'h00000033);

    // SH at 0x202: upper halfword lanes, immediate grant
    applyStimulus(1'b1, 1'b1, 3'b001, 32'h0000_0202, 32'h1234ABCD, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput("sh_mem_req", 32'(mem_req), 32'd1);
    checkOutput("sh_mem_we", 32'(mem_we), 32'd1);
    checkOutput("sh_mem_addr", mem_addr, 32'h0000_0200);
    checkOutput("sh_mem_be", 32'(mem_be), 32'b1100);
    checkOutput("sh_mem_wdata", mem_wdata, 32'hABCDABCD);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("sh_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("sh_rsp_err", 32'(lsu_rsp_err), 32'd0);
    checkOutput("sh_rsp_rdata", lsu_rsp_rdata, 32'h0);
    checkOutput("sh_rsp_addr", lsu_rsp_addr, 32'h0000_0202);
    checkOutput("sh_rsp_no_req", 32'(mem_req), 32'd0);
    step();
    checkOutput("sh_idle_we", 32'(mem_we), 32'd0);
    checkOutput("sh_idle_be", 32'(mem_be), 32'd0);
    checkOutput("sh_idle_wdata", mem_wdata, 32'h0);

    // SB at 0x101 with one stalled grant cycle: fields must stay stable
    applyStimulus(1'b1, 1'b1, 3'b000, 32'h0000_0101, 32'hFFFFFF55, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("sb_stall_be", 32'(mem_be), 32'b0010);
    checkOutput("sb_stall_wdata", mem_wdata, 32'h55555555);
    step();
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput("sb_hold_req", 32'(mem_req), 32'd1);
    checkOutput("sb_hold_addr", mem_addr, 32'h0000_0100);
    checkOutput("sb_hold_be", 32'(mem_be), 32'b0010);
    checkOutput("sb_hold_wdata", mem_wdata, 32'h55555555);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("sb_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("sb_rsp_err", 32'(lsu_rsp_err), 32'd0);
    step();

    // Illegal requests
    runIllegal("lw_mis",   1'b0, 3'b010, 32'h0000_0101);
    runIllegal("sbu",      1'b1, 3'b100, 32'h0000_0104);
    runIllegal("f3_011",   1'b0, 3'b011, 32'h0000_0010);
    runIllegal("lhu_mis",  1'b0, 3'b101, 32'h0000_0203);
    runIllegal("sw_mis",   1'b1, 3'b010, 32'h0000_0302);

    // Timeout: grant never comes, abort after 15 REQ cycles
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("to_req_%0d", i), 32'(mem_req), 32'd1);
      step();
    end
    checkOutput("to_rsp_valid", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("to_rsp_err", 32'(lsu_rsp_err), 32'd1);
    checkOutput("to_req_drop", 32'(mem_req), 32'd0);
    checkOutput("to_rsp_rdata", lsu_rsp_rdata, 32'h0);
    step();
    checkOutput("to_idle", 32'(lsu_req_ready), 32'd1);

    // Grant in the 15th REQ cycle still completes normally
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0304, 32'h0BADF00D, 5'd0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 14; i++) step();
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput("to_late_req", 32'(mem_req), 32'd1);
    checkOutput("to_late_wdata", mem_wdata, 32'h0BADF00D);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("to_late_valid", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("to_late_err", 32'(lsu_rsp_err), 32'd0);
    step();

    // Reset while waiting for load data; a later rvalid must be ignored
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd5);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b1, 1'b0, 32'h0);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("rw_busy", 32'(lsu_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rw_no_rsp", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("rw_idle", 32'(lsu_req_ready), 32'd1);
    driveMem(1'b0, 1'b1, 32'hCAFEBABE);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("rw_stray_rsp", 32'(lsu_rsp_valid), 32'd0);
    checkOutput("rw_stray_busy", 32'(lsu_busy), 32'd0);
    step();
    checkOutput("rw_stray_rsp2", 32'(lsu_rsp_valid), 32'd0);

    // Request held while busy, accepted in the cycle after RESP
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h0000_0500, 32'hCAFEF00D, 5'd0);
    step();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd9);
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput("bb_st_addr", mem_addr, 32'h0000_0500);
    checkOutput("bb_busy_ready", 32'(lsu_req_ready), 32'd0);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("bb_st_rsp", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("bb_rsp_ready", 32'(lsu_req_ready), 32'd0);
    step();
    checkOutput("bb_idle_ready", 32'(lsu_req_ready), 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    driveMem(1'b1, 1'b0, 32'h0);
    checkOutput("bb_ld_req", 32'(mem_req), 32'd1);
    checkOutput("bb_ld_addr", mem_addr, 32'h0000_0100);
    checkOutput("bb_ld_we", 32'(mem_we), 32'd0);
    step();
    driveMem(1'b0, 1'b1, 32'h76543210);
    step();
    driveMem(1'b0, 1'b0, 32'h0);
    checkOutput("bb_ld_rsp", 32'(lsu_rsp_valid), 32'd1);
    checkOutput("bb_ld_rd", 32'(lsu_rsp_rd), 32'd9);
    checkOutput("bb_ld_data", lsu_rsp_rdata, 32'h76543210);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
